// File: rtl/crc32_24_frame_ctrl.sv
// Frame-level CRC-32 sequencer (poly 0x04C11DB7, MSB-first).
// Full 24-bit beats take one parallel crc32_24 step per cycle. A partial last
// beat (1 or 2 bytes) is finished one bit per cycle by a serial LFSR. The
// serial path is built from the same per-bit step as the parallel one, so the
// two are bit-exact for the same bits.
module crc32_24_frame_ctrl #(
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_data,
  input  logic        in_last,
  input  logic [1:0]  in_nbytes,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_crc,
  output logic        busy
);

  localparam logic [31:0] Poly = 32'h04C11DB7;

  localparam logic [1:0] StAcc  = 2'd0;
  localparam logic [1:0] StTail = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] tail_q, tail_d;
  logic [4:0]  bitcnt_q, bitcnt_d;

  // One bit of the MSB-first LFSR.
  function automatic logic [31:0] crc_bit(input logic [31:0] crc, input logic din);
    logic fb;
    fb = crc[31] ^ din;
    return {crc[30:0], 1'b0} ^ (fb ? Poly : 32'h0);
  endfunction

  // 24 bits per step, data[23] first.
  function automatic logic [31:0] crc32_24(input logic [31:0] crc, input logic [23:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 23; i >= 0; i--) begin
      c = crc_bit(c, data[i]);
    end
    return c;
  endfunction

  // Next-state and handshake outputs for the ACC/TAIL/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    tail_d    = tail_q;
    bitcnt_d  = bitcnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      StAcc: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!in_last) begin
            crc_d = crc32_24(crc_q, in_data);
          end else begin
            unique case (in_nbytes)
              2'd3: begin
                crc_d   = crc32_24(crc_q, in_data);
                state_d = StDone;
              end
              2'd2: begin
                tail_d   = in_data[23:8];
                bitcnt_d = 5'd16;
                state_d  = StTail;
              end
              2'd1: begin
                tail_d   = {in_data[23:16], 8'h00};
                bitcnt_d = 5'd8;
                state_d  = StTail;
              end
              2'd0: begin
                state_d = StDone;
              end
            endcase
          end
        end
      end
      StTail: begin
        crc_d    = crc_bit(crc_q, tail_q[15]);
        tail_d   = {tail_q[14:0], 1'b0};
        bitcnt_d = bitcnt_q - 5'd1;
        if (bitcnt_q == 5'd1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          crc_d   = INIT;
          state_d = StAcc;
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean frame start.
        crc_d   = INIT;
        state_d = StAcc;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StAcc;
      crc_q    <= INIT;
      tail_q   <= 16'h0000;
      bitcnt_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      tail_q   <= tail_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  assign out_crc = crc_q ^ XOR_OUT;
  assign busy    = (state_q != StAcc);

endmodule
